// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_IF  = 2'd1,
    ST_GNT_MEM = 2'd2,
    ST_DRAIN   = 2'd3
  } arb_state_e;

  localparam int unsigned TIMEOUT_DEF = 255;
  localparam logic [3:0]  SEL_ALL     = 4'hF;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Counts cycles of an outstanding bus request; expired flags the cycle in which
// the request has been high for TIMEOUT cycles (never when TIMEOUT is 0).
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam bit            ENABLED = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] LAST  = ENABLED ? TO_W'(TIMEOUT - 1) : '0;

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // cnt_q holds completed high cycles, so the current cycle is the TIMEOUT-th at LAST
  assign expired = ENABLED && enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serialises instruction-fetch and data-port transactions onto one shared bus
// with MEM priority, fetch anti-starvation alternation, flush drain and timeout.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  input  logic              flush_i,
  output logic              stallreq_o,
  output logic              err_o
);

  arb_state_e        state_q, state_d;
  logic              last_mem_q, last_mem_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic              if_ack_q, if_ack_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              mem_ack_q, mem_ack_d;
  logic              err_q, err_d;
  logic              grant;
  logic              expired;
  logic              if_want, mem_want;

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant),
    .enable  (bus_req_q),
    .expired (expired)
  );

  // A master still holds its request during its ack cycle; masking avoids a re-grant.
  assign if_want  = if_req_i & ~if_ack_q & ~flush_i;
  assign mem_want = mem_req_i & ~mem_ack_q;

  always_comb begin
    state_d     = state_q;
    last_mem_d  = last_mem_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    err_d       = 1'b0;
    grant       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_want && !(last_mem_q && if_want)) begin
          state_d     = ST_GNT_MEM;
          grant       = 1'b1;
          last_mem_d  = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_sel_d   = mem_sel_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
        end else if (if_want) begin
          state_d     = ST_GNT_IF;
          grant       = 1'b1;
          last_mem_d  = 1'b0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = SEL_ALL;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
        end
      end

      ST_GNT_IF: begin
        if (bus_ack_i) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          if_data_d = bus_rdata_i;
          if_ack_d  = 1'b1;
        end else if (expired) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          if_data_d = '0;
          if_ack_d  = 1'b1;
          err_d     = 1'b1;
        end else if (flush_i) begin
          state_d = ST_DRAIN;
        end
      end

      ST_GNT_MEM: begin
        if (bus_ack_i) begin
          state_d     = ST_IDLE;
          bus_req_d   = 1'b0;
          mem_rdata_d = bus_rdata_i;
          mem_ack_d   = 1'b1;
        end else if (expired) begin
          state_d     = ST_IDLE;
          bus_req_d   = 1'b0;
          mem_rdata_d = '0;
          mem_ack_d   = 1'b1;
          err_d       = 1'b1;
        end
      end

      // Flushed fetch: finish the bus cycle silently, fetch data is discarded
      ST_DRAIN: begin
        if (bus_ack_i) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
        end else if (expired) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          err_d     = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      last_mem_q  <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_data_q   <= '0;
      if_ack_q    <= 1'b0;
      mem_rdata_q <= '0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_data_q   <= if_data_d;
      if_ack_q    <= if_ack_d;
      mem_rdata_q <= mem_rdata_d;
      mem_ack_q   <= mem_ack_d;
      err_q       <= err_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_data_o   = if_data_q;
  assign if_ack_o    = if_ack_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ack_o   = mem_ack_q;
  assign err_o       = err_q;
  assign stallreq_o  = (if_req_i & ~if_ack_q) | (mem_req_i & ~mem_ack_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter against a transaction-level model.
module tb_bus_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ack_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stallreq_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  // Model state: owner of the most recent grant, last fetch data delivered
  bit          last_mem_m = 1'b0;
  logic [31:0] if_data_m  = '0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO),
    .TO_W    (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_data_o   (if_data_o),
    .if_ack_o    (if_ack_o),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_sel_i   (mem_sel_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_ack_o   (mem_ack_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_sel_o   (bus_sel_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .flush_i     (flush_i),
    .stallreq_o  (stallreq_o),
    .err_o       (err_o)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge where the next rising edge must grant the given master.
  // d = idle bus cycles before the ack; d >= TMO means the bus never acks.
  task automatic serve(input bit is_mem, input int d, input logic [31:0] ea,
                       input bit ewe, input logic [3:0] esel, input logic [31:0] ewd,
                       input logic [31:0] rd, input bit other_pending);
    bit to;
    bit done;
    to = (d >= TMO);
    done = 1'b0;
    bus_rdata_i = $urandom;
    tick();
    chk("bus_req_rise", bus_req_o, 1);
    chk("bus_addr", bus_addr_o, ea);
    chk("bus_we", bus_we_o, ewe);
    chk("bus_sel", bus_sel_o, esel);
    if (ewe) chk("bus_wdata", bus_wdata_o, ewd);
    last_mem_m = is_mem;
    for (int i = 0; i < TMO; i++) begin
      if (!done) begin
        if (i > 0) chk("bus_req_hold", bus_req_o, 1);
        chk("no_early_ack", {29'b0, err_o, if_ack_o, mem_ack_o}, 0);
        if (!to && i == d) begin
          bus_ack_i = 1'b1;
          bus_rdata_i = rd;
          tick();
          bus_ack_i = 1'b0;
          bus_rdata_i = $urandom;
          done = 1'b1;
        end else begin
          tick();
        end
      end
    end
    chk("bus_req_drop", bus_req_o, 0);
    if (is_mem) begin
      chk("mem_ack", mem_ack_o, 1);
      chk("if_ack_idle", if_ack_o, 0);
      chk("mem_rdata", mem_rdata_o, to ? 32'h0 : rd);
    end else begin
      chk("if_ack", if_ack_o, 1);
      chk("mem_ack_idle", mem_ack_o, 0);
      chk("if_data", if_data_o, to ? 32'h0 : rd);
      if_data_m = to ? 32'h0 : rd;
    end
    chk("err", err_o, to);
    chk("stallreq_at_ack", stallreq_o, other_pending);
    if (is_mem) mem_req_i = 1'b0;
    else        if_req_i  = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_acks", {29'b0, err_o, if_ack_o, mem_ack_o}, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_if_data", if_data_o, 0);
    chk("rst_mem_rdata", mem_rdata_o, 0);
    chk("rst_stall", stallreq_o, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Fetch only
    if_req_i = 1'b1;
    if_addr_i = 32'h0000_0010;
    #1 chk("fetch_stall_req", stallreq_o, 1);
    serve(1'b0, 2, 32'h0000_0010, 1'b0, 4'hF, 32'h0, 32'h3401_1100, 1'b0);
    tick();
    chk("fetch_stall_after", stallreq_o, 0);
    chk("fetch_ack_single", if_ack_o, 0);
    chk("fetch_data_held", if_data_o, 32'h3401_1100);

    // Simultaneous: MEM first, then IF even though MEM reasserts
    if_req_i = 1'b1;
    if_addr_i = 32'h0000_0014;
    mem_req_i = 1'b1;
    mem_we_i = 1'b1;
    mem_addr_i = 32'h0000_0080;
    mem_wdata_i = 32'hDEAD_BEEF;
    mem_sel_i = 4'b0011;
    serve(1'b1, 1, 32'h80, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h1111_2222, 1'b1);
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_addr_i = 32'h0000_0084;
    mem_sel_i = 4'hF;
    serve(1'b0, 0, 32'h14, 1'b0, 4'hF, 32'h0, 32'h5555_6666, 1'b1);
    serve(1'b1, 0, 32'h84, 1'b0, 4'hF, 32'h0, 32'h7777_8888, 1'b0);
    tick();

    // Starvation: both held continuously, grants must alternate
    if_req_i = 1'b1;
    if_addr_i = 32'h0000_0100;
    mem_req_i = 1'b1;
    mem_addr_i = 32'h0000_0300;
    for (int k = 0; k < 4; k++) begin
      bit w;
      w = !last_mem_m;
      serve(w, k % 3, w ? 32'h300 : 32'h100, 1'b0, 4'hF, 32'h0, $urandom, 1'b1);
      if (w) mem_req_i = 1'b1;
      else   if_req_i  = 1'b1;
    end
    if_req_i = 1'b0;
    mem_req_i = 1'b0;
    tick();
    chk("starve_idle", bus_req_o, 0);

    // Timeout on a mem read, then an ack coinciding with the timeout cycle
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_addr_i = 32'h0000_0090;
    serve(1'b1, TMO, 32'h90, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
    tick();
    chk("timeout_err_pulse", err_o, 0);
    mem_req_i = 1'b1;
    serve(1'b1, TMO - 1, 32'h90, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0);
    tick();

    // Flush mid-fetch with a pending mem request
    if_req_i = 1'b1;
    if_addr_i = 32'h0000_0040;
    tick();
    chk("flush_grant", bus_req_o, 1);
    last_mem_m = 1'b0;
    flush_i = 1'b1;
    if_req_i = 1'b0;
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_addr_i = 32'h0000_0200;
    mem_sel_i = 4'hF;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_hold", bus_req_o, 1);
      chk("drain_no_ack", {30'b0, if_ack_o, mem_ack_o}, 0);
      tick();
    end
    chk("drain_hold_last", bus_req_o, 1);
    bus_ack_i = 1'b1;
    bus_rdata_i = 32'hBAD0_BAD0;
    tick();
    bus_ack_i = 1'b0;
    chk("drain_drop", bus_req_o, 0);
    chk("drain_acks", {29'b0, err_o, if_ack_o, mem_ack_o}, 0);
    chk("drain_if_data", if_data_o, if_data_m);
    serve(1'b1, 0, 32'h200, 1'b0, 4'hF, 32'h0, 32'h0F0F_0F0F, 1'b0);
    tick();

    // Flush with a bus that never acks: err only
    if_req_i = 1'b1;
    if_addr_i = 32'h0000_0044;
    tick();
    last_mem_m = 1'b0;
    flush_i = 1'b1;
    if_req_i = 1'b0;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_to_hold", bus_req_o, 1);
      tick();
    end
    chk("drain_to_drop", bus_req_o, 0);
    chk("drain_to_err", err_o, 1);
    chk("drain_to_acks", {30'b0, if_ack_o, mem_ack_o}, 0);
    chk("drain_to_data", if_data_o, if_data_m);
    tick();

    // Flush in IDLE blocks a fetch for that cycle
    if_req_i = 1'b1;
    if_addr_i = 32'h0000_0048;
    flush_i = 1'b1;
    tick();
    chk("idle_flush_block", bus_req_o, 0);
    flush_i = 1'b0;
    serve(1'b0, 1, 32'h48, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 1'b0);
    tick();

    // Asynchronous reset mid-transaction
    mem_req_i = 1'b1;
    mem_we_i = 1'b1;
    mem_addr_i = 32'h0000_0400;
    mem_wdata_i = 32'h0BAD_CAFE;
    tick();
    chk("pre_rst_req", bus_req_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_req", bus_req_o, 0);
    chk("rst_mid_acks", {29'b0, err_o, if_ack_o, mem_ack_o}, 0);
    chk("rst_mid_addr", bus_addr_o, 0);
    chk("rst_mid_if_data", if_data_o, 0);
    chk("rst_mid_mem_rdata", mem_rdata_o, 0);
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
    tick();
    rst = 1'b1;
    last_mem_m = 1'b0;
    if_data_m = '0;
    tick();
    chk("post_rst_idle", {30'b0, bus_req_o, mem_ack_o}, 0);
    if_req_i = 1'b1;
    if_addr_i = 32'h0000_0050;
    serve(1'b0, 0, 32'h50, 1'b0, 4'hF, 32'h0, 32'hA5A5_5A5A, 1'b0);
    tick();

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      int pat;
      int d1;
      int d2;
      int gap;
      bit first;
      logic [31:0] ia;
      logic [31:0] ma;
      logic [31:0] mw;
      logic [3:0]  ms;
      bit          mwe;
      pat = $urandom_range(0, 2);
      d1  = $urandom_range(0, TMO + 1);
      d2  = $urandom_range(0, TMO + 1);
      gap = $urandom_range(1, 3);
      ia  = $urandom & 32'hFFFF_FFFC;
      ma  = $urandom & 32'hFFFF_FFFC;
      mw  = $urandom;
      ms  = 4'($urandom_range(0, 15));
      mwe = 1'($urandom_range(0, 1));
      if_addr_i = ia;
      mem_addr_i = ma;
      mem_wdata_i = mw;
      mem_sel_i = ms;
      mem_we_i = mwe;
      if (pat == 0) begin
        if_req_i = 1'b1;
        serve(1'b0, d1, ia, 1'b0, 4'hF, 32'h0, $urandom, 1'b0);
      end else if (pat == 1) begin
        mem_req_i = 1'b1;
        serve(1'b1, d1, ma, mwe, ms, mw, $urandom, 1'b0);
      end else begin
        if_req_i = 1'b1;
        mem_req_i = 1'b1;
        first = !last_mem_m;
        if (first) begin
          serve(1'b1, d1, ma, mwe, ms, mw, $urandom, 1'b1);
          serve(1'b0, d2, ia, 1'b0, 4'hF, 32'h0, $urandom, 1'b0);
        end else begin
          serve(1'b0, d1, ia, 1'b0, 4'hF, 32'h0, $urandom, 1'b1);
          serve(1'b1, d2, ma, mwe, ms, mw, $urandom, 1'b0);
        end
      end
      repeat (gap) tick();
      chk("rand_quiet", {29'b0, err_o, if_ack_o, mem_ack_o}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Arbitrates one shared memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage) of the five-stage pipeline. Transactions are serialised through a registered req/ack state machine. A stall request goes to the pipeline control block, a flush from control aborts fetches, and a timeout counter recovers from a bus that never acknowledges.

Parameters:
- ADDR_W, 32, address width of master and bus ports
- DATA_W, 32, data width
- TIMEOUT, 255, cycles bus_req_o may stay high without bus_ack_i; 0 disables the timeout
- TO_W, 8, timeout counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_data_o  out  DATA_W  fetched instruction, valid with if_ack_o
- if_ack_o  out  1  one-cycle fetch completion pulse
- mem_req_i  in  1  data request, held until mem_ack_o
- mem_we_i  in  1  1 = write
- mem_sel_i  in  4  byte enables
- mem_addr_i  in  ADDR_W  data address
- mem_wdata_i  in  DATA_W  write data
- mem_rdata_o  out  DATA_W  read data, valid with mem_ack_o
- mem_ack_o  out  1  one-cycle data completion pulse
- bus_req_o  out  1  bus cycle active
- bus_we_o  out  1  bus write
- bus_sel_o  out  4  bus byte enables
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_rdata_i  in  DATA_W  bus read data
- bus_ack_i  in  1  bus completion, sampled only while bus_req_o=1
- flush_i  in  1  pipeline flush from control
- stallreq_o  out  1  to pipeline control
- err_o  out  1  one-cycle timeout pulse, coincident with the affected ack

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs are registered and clear to 0, including data/address buses, the last_mem flag and the timeout counter. A bus cycle in progress is abandoned immediately and no ack is issued.
- States: IDLE, GNT_IF, GNT_MEM, DRAIN.
- IDLE arbitration: mem_req_i wins over if_req_i, except when last_mem=1 and if_req_i=1; then IF wins (alternation, prevents fetch starvation).
- IDLE with flush_i=1: if_req_i is ignored that cycle.
- Grant: on entering GNT_x, latch the master's addr/we/sel/wdata onto the bus registers and set bus_req_o=1 in the next cycle. An IF grant drives we=0 and sel=4'hF. last_mem updates at each grant (1 for MEM, 0 for IF).
- GNT_x with bus_ack_i=1:
  - drop bus_req_o
  - register bus_rdata_i into if_data_o or mem_rdata_o
  - pulse the matching ack for one cycle
  - return to IDLE
- Latency: request seen at cycle N gives bus_req_o at N+1. A bus ack at cycle M gives master ack at M+1. Minimum 3 cycles per transaction; no back-to-back grants without an IDLE cycle.
- GNT_IF with flush_i=1 and no bus_ack_i in the same cycle: go to DRAIN. bus_req_o stays high until bus_ack_i or timeout, then go to IDLE with no if_ack_o and if_data_o unchanged.
- GNT_IF with flush_i and bus_ack_i in the same cycle: the ack completes normally, then the flush takes effect.
- flush_i has no effect in GNT_MEM or DRAIN.
- Timeout: the counter clears on each grant and increments each cycle bus_req_o=1. When it reaches TIMEOUT with no bus_ack_i:
  - drop bus_req_o
  - pulse the owner's ack with data 0 and err_o=1 (DRAIN pulses err_o only)
  - return to IDLE
- A bus ack in the same cycle as the timeout is treated as an ack; err_o stays 0.
- stallreq_o (combinational) = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o).
- An ack pulse is never issued to a master whose request is not currently granted.

Decomposition:
- Shared defines file gets the state encodings (2 bits), the default TIMEOUT, and the bus sel-all constant 4'hF.
- One natural sub-module: bus_timeout_ctr. Inputs clk, rst, clear, enable; output expired.
- Arbitration and the FSM remain in bus_arbiter.

Test Plan:
- Fetch only: if_req_i=1, if_addr_i=0x0000_0010, bus acks after 2 cycles with 0x3401_1100 -> bus_req_o rises 1 cycle after the request; if_ack_o pulses once with if_data_o=0x3401_1100; stallreq_o=0 after the ack.
- Simultaneous: if_req_i and mem_req_i both high, mem write to 0x80 of 0xDEAD_BEEF, sel=4'b0011 -> MEM granted first with bus_we_o=1 and bus_sel_o=3; then IF granted even though mem_req_i is reasserted.
- Flush mid-fetch: flush_i pulsed 1 cycle after the IF grant, bus acks 3 cycles later -> bus_req_o held until the ack; if_ack_o never pulses; FSM returns to IDLE and serves a pending mem_req_i next.
- Timeout: TIMEOUT=4, bus never acks a mem read -> bus_req_o drops after 4 high cycles; mem_ack_o=1, err_o=1, mem_rdata_o=0 in the same cycle.
- Reset mid-transaction: rst driven low while bus_req_o=1 -> bus_req_o=0 and all acks 0 immediately, with no clock edge needed; after release, a new if_req_i is served normally.
- Starvation: mem_req_i held continuously with if_req_i=1 -> grants strictly alternate MEM, IF, MEM, IF.
